rf_writeback: RTL

Write-back stage that is the write-side initiator for the register file (sync write, async read).
- Merges results from the ALU path (never stalls) and the load path (valid/ready, buffered) into the single register-file write port.
- Provides a forwarding lookup so operand fetch sees writes that the register file does not yet show.
- Sits between execute/memory and the register file.

---
 rtl/rf_writeback_pkg.sv | 21 ++
 rtl/rf_wb_queue.sv | 106 ++++++++++
 rtl/rf_writeback.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rf_writeback_pkg.sv
// Shared sizing defaults and write-slot selection type for the register-file
// write-back stage and its load queue.
package rf_writeback_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 3;
  localparam int DEF_ZERO_ADDR = 0;
  localparam int DEF_LQ_DEPTH  = 2;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ALU   = 2'd1,
    SEL_QUEUE = 2'd2
  } wb_sel_e;

  // Counter width able to hold 0..depth inclusive.
  function automatic int lq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rf_wb_queue.sv
// Circular load queue with per-entry valid bits, kill-by-address and a
// combinational youngest-first address lookup.
module rf_wb_queue
  import rf_writeback_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_LQ_DEPTH,
  localparam int CNT_W = lq_cnt_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_kill,
  input  logic [ADDR_W-1:0] i_kill_addr,
  input  logic [ADDR_W-1:0] i_look_addr,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_head_valid,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic              o_look_hit,
  output logic [DATA_W-1:0] o_look_data
);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_valid  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (i_pop && r_rd_ptr == PTR_W'(j)) begin
          r_valid[j] <= 1'b0;
        end else if (i_kill && r_addr[j] == i_kill_addr) begin
          r_valid[j] <= 1'b0;
        end
        // A load arriving on the same edge as a younger ALU write is born dead.
        if (i_push && r_wr_ptr == PTR_W'(j)) begin
          r_valid[j] <= !(i_kill && i_push_addr == i_kill_addr);
        end
      end
      if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: payload storage has no reset; r_valid and r_count alone decide
  // whether a slot means anything, so stale payload is never observed.
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_count      = r_count;
  assign o_head_valid = r_valid[r_rd_ptr];
  assign o_head_addr  = r_addr[r_rd_ptr];
  assign o_head_data  = r_data[r_rd_ptr];

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the last match found is the youngest.
  // NOTE: every output of this block gets a default first, so no path
  // through it can leave a value held and infer a latch.
  always_comb begin
    o_look_hit  = 1'b0;
    o_look_data = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sum = {1'b0, r_rd_ptr} + (PTR_W + 1)'(i);
      if (w_sum >= (PTR_W + 1)'(DEPTH)) w_sum = w_sum - (PTR_W + 1)'(DEPTH);
      w_idx = w_sum[PTR_W-1:0];
      if (r_count > CNT_W'(i) && r_valid[w_idx] && r_addr[w_idx] == i_look_addr) begin
        o_look_hit  = 1'b1;
        o_look_data = r_data[w_idx];
      end
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Write-back stage: merges the never-stalling ALU path and the buffered load
// path into one registered register-file write port, with forwarding lookup.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ZERO_ADDR = DEF_ZERO_ADDR,
  parameter int LQ_DEPTH  = DEF_LQ_DEPTH
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              busy
);

  localparam int                CNT_W = lq_cnt_w(LQ_DEPTH);
  localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(ZERO_ADDR);

  logic              r_we;
  logic [ADDR_W-1:0] r_w_addr;
  logic [DATA_W-1:0] r_w_data;

  logic              w_alu_wr;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count;
  logic              w_head_valid;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_look_hit;
  logic [DATA_W-1:0] w_look_data;
  wb_sel_e           w_sel;

  // An ALU result to the zero register is idle for selection purposes.
  assign w_alu_wr = alu_valid && (alu_addr != ZERO);
  assign ld_ready = (w_count < CNT_W'(LQ_DEPTH));
  assign w_push   = ld_valid && ld_ready && (ld_addr != ZERO);
  assign w_pop    = (w_sel == SEL_QUEUE);

  always_comb begin
    w_sel = SEL_NONE;
    if (w_alu_wr) begin
      w_sel = SEL_ALU;
    end else if (w_count != '0) begin
      w_sel = SEL_QUEUE;
    end
  end

  rf_wb_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (LQ_DEPTH)
  ) u_queue (
    .clock        (clock),
    .n_rst        (n_rst),
    .i_push       (w_push),
    .i_push_addr  (ld_addr),
    .i_push_data  (ld_data),
    .i_pop        (w_pop),
    .i_kill       (w_alu_wr),
    .i_kill_addr  (alu_addr),
    .i_look_addr  (fwd_addr),
    .o_count      (w_count),
    .o_head_valid (w_head_valid),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_look_hit   (w_look_hit),
    .o_look_data  (w_look_data)
  );

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_we     <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else begin
      case (w_sel)
        SEL_ALU: begin
          r_we     <= 1'b1;
          r_w_addr <= alu_addr;
          r_w_data <= alu_data;
        end
        SEL_QUEUE: begin
          // A killed head still uses its drain slot, but writes nothing.
          r_we <= w_head_valid;
          if (w_head_valid) begin
            r_w_addr <= w_head_addr;
            r_w_data <= w_head_data;
          end
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  assign rf_we     = r_we;
  assign rf_w_addr = r_w_addr;
  assign rf_w_data = r_w_data;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != ZERO) begin
      if (w_look_hit) begin
        fwd_hit  = 1'b1;
        fwd_data = w_look_data;
      end else if (r_we && r_w_addr == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = r_w_data;
      end
    end
  end

  assign busy = (w_count != '0) || r_we;

endmodule
